// File: rtl/sprite_sched_pkg.sv
// Shared types and default sizes for the per-scanline sprite scheduler.
package sprite_sched_pkg;

  localparam int DEF_N_SPR = 8;
  localparam int DEF_SLOTS = 4;
  localparam int DEF_CORDW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sched_state_t;

  // One object table entry: enable, signed top line, scaled height in lines.
  typedef struct packed {
    logic                        en;
    logic signed [DEF_CORDW-1:0] y;
    logic        [DEF_CORDW-1:0] h;
  } obj_t;

endpackage

// File: rtl/spr_line_hit.sv
// Combinational test of whether one sprite covers a given screen line.
// Shared with the collision logic, so it stays free of any scan state.
module spr_line_hit
  import sprite_sched_pkg::*;
(
  input  obj_t                        i_obj,
  input  logic signed [DEF_CORDW:0]   i_line_y,
  output logic                        o_hit
);

  logic signed [DEF_CORDW:0] top;
  logic signed [DEF_CORDW:0] bot;

  // Extend by one bit so y + h never overflows for legal tables; h is a count, so zero-extend it.
  assign top   = {i_obj.y[DEF_CORDW-1], i_obj.y};
  assign bot   = top + $signed({1'b0, i_obj.h});
  assign o_hit = i_obj.en && (i_line_y >= top) && (i_line_y < bot);

endmodule

// File: rtl/sprite_line_sched.sv
// Per-scanline sprite scheduler: on each start-of-line pulse it walks the
// object table one entry per cycle and publishes up to SLOTS sprite ids that
// intersect the next line, lowest id first.
// Optional feature: define SPRITE_SCHED_OVF_CNT_EN to count overflowed lines per frame.
module sprite_line_sched
  import sprite_sched_pkg::*;
#(
  parameter  int N_SPR = DEF_N_SPR,
  parameter  int SLOTS = DEF_SLOTS,
  localparam int CORDW = DEF_CORDW,
  localparam int IDW   = $clog2(N_SPR)
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic                    i_frame,
  input  logic                    i_line,
  input  logic signed [CORDW-1:0] i_sy,
  input  logic                    i_wr_en,
  input  logic [IDW-1:0]          i_wr_id,
  input  logic                    i_wr_en_obj,
  input  logic signed [CORDW-1:0] i_wr_y,
  input  logic [CORDW-1:0]        i_wr_h,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [SLOTS-1:0]        o_slot_vld,
  output logic [SLOTS*IDW-1:0]    o_slot_id,
  output logic                    o_overflow,
  output logic [7:0]              o_ovf_cnt
);

  localparam int CNTW = $clog2(SLOTS + 1);

  obj_t                    tbl [N_SPR];
  sched_state_t            state_q, state_d;
  logic [IDW-1:0]          idx_q;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [SLOTS*IDW-1:0]    slots_q, slots_d;
  logic                    wovf_q, wovf_d;
  logic signed [CORDW:0]   tgt_q, tgt_next;
  logic [SLOTS-1:0]        vld_d;
  logic                    hit_raw, hit, start, last;

  // Object table: writes land at the edge, so an entry tested this cycle sees its old value.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_SPR; i++) tbl[i] <= '0;
    end else if (i_wr_en) begin
      tbl[i_wr_id] <= '{en: i_wr_en_obj, y: i_wr_y, h: i_wr_h};
    end
  end

  assign tgt_next = {i_sy[CORDW-1], i_sy} + {{CORDW{1'b0}}, 1'b1};

  spr_line_hit u_hit (
    .i_obj    (tbl[idx_q]),
    .i_line_y (tgt_q),
    .o_hit    (hit_raw)
  );

  assign hit    = (state_q == SCAN) && hit_raw;
  assign o_busy = (state_q == SCAN);

  // State register.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: a line pulse is only accepted while idle; the scan ends after the last entry.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_line) begin
          start   = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IDW'(N_SPR - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Work list update for the entry under test, plus its thermometer valid mask.
  always_comb begin
    cnt_d   = cnt_q;
    slots_d = slots_q;
    wovf_d  = wovf_q;
    vld_d   = '0;
    if (hit) begin
      if (cnt_q < CNTW'(SLOTS)) begin
        for (int k = 0; k < SLOTS; k++) begin
          if (CNTW'(k) == cnt_q) slots_d[k*IDW +: IDW] = idx_q;
        end
        cnt_d = cnt_q + CNTW'(1);
      end else begin
        wovf_d = 1'b1;
      end
    end
    for (int k = 0; k < SLOTS; k++) vld_d[k] = (CNTW'(k) < cnt_d);
  end

  // Scan datapath: latch the target line on launch, then step through the table.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      tgt_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      slots_q <= '0;
      wovf_q  <= 1'b0;
    end else if (start) begin
      tgt_q   <= tgt_next;
      idx_q   <= '0;
      cnt_q   <= '0;
      slots_q <= '0;
      wovf_q  <= 1'b0;
    end else if (state_q == SCAN) begin
      idx_q   <= idx_q + IDW'(1);
      cnt_q   <= cnt_d;
      slots_q <= slots_d;
      wovf_q  <= wovf_d;
    end
  end

  // Published slot list: updated once per scan together with the done pulse, held otherwise.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      o_done     <= 1'b0;
      o_slot_vld <= '0;
      o_slot_id  <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= last;
      if (last) begin
        o_slot_vld <= vld_d;
        o_slot_id  <= slots_d;
        o_overflow <= wovf_d;
      end
    end
  end

`ifdef SPRITE_SCHED_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  // Saturating count of overflowed lines; the frame pulse wins over a coincident increment.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n)                                       ovf_cnt_q <= 8'd0;
    else if (i_frame)                                   ovf_cnt_q <= 8'd0;
    else if (o_done && o_overflow && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
  end

  assign o_ovf_cnt = ovf_cnt_q;
`else
  logic unused_frame;
  assign unused_frame = i_frame;
  assign o_ovf_cnt    = 8'd0;
`endif

endmodule

// File: doc/sprite_line_sched.md
# sprite_line_sched

Per-scanline sprite scheduler that sits ahead of the shared sprite drawing engines. It holds a small object table of up to N_SPR on-screen sprites, each with an enable, top y-coordinate and scaled height. During horizontal blanking it scans the table once per line and selects at most SLOTS sprites that intersect the next line. It publishes that slot list so the line's sprite engines and ROM ports can be started only for the selected sprites.

## Interface
- N_SPR, 8: object table entries; sprite id width IDW = $clog2(N_SPR) (localparam)
- SLOTS, 4: maximum sprites drawn per line
- CORDW, 16: signed coordinate width
- i_clk_pix  in  1  pixel clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_frame  in  1  start-of-frame pulse
- i_line  in  1  start-of-line pulse; launches a scan
- i_sy  in  CORDW signed  current screen line, sampled with i_line
- i_wr_en  in  1  object table write strobe
- i_wr_id  in  IDW  entry to write
- i_wr_en_obj  in  1  entry enable
- i_wr_y  in  CORDW signed  sprite top line
- i_wr_h  in  CORDW  scaled height in lines (SPR_HEIGHT*scale_y)
- o_busy  out  1  scan in progress
- o_done  out  1  one-cycle pulse when slot list updated
- o_slot_vld  out  SLOTS  per-slot valid
- o_slot_id  out  SLOTS*IDW  slot k id at bits [k*IDW +: IDW]
- o_overflow  out  1  more than SLOTS hits on the last scanned line
- o_ovf_cnt  out  8  overflowed lines this frame (macro only)

## Operation
- Table reset: every entry en=0, y=0, h=0. A write lands at the clock edge and is visible to the scan from the next cycle.
- FSM states: IDLE, SCAN. Reset puts the FSM in IDLE.
- IDLE → SCAN on i_line:
  - latch target line L = i_sy + 1, computed in CORDW+1 bits;
  - idx = 0, work count = 0, work overflow = 0.
- SCAN tests one entry per cycle at idx.
  - Hit condition: en && L >= y && L < y + h, all signed CORDW+1.
  - h = 0 never hits. y + h must not wrap.
  - Hit with count < SLOTS: write id into work slot[count], then count++.
  - Hit with count == SLOTS: set work overflow.
- Slots fill in ascending id order. Lower id means higher priority and lower slot index.
- After idx = N_SPR-1 (SCAN → IDLE at that edge):
  - o_slot_vld = thermometer of count;
  - o_slot_id = work slots, with unused slots 0;
  - o_overflow = work overflow;
  - o_done = 1 for one cycle.
- i_line during SCAN is ignored. The scan in progress completes unchanged.
- A write to the entry at idx in the same cycle it is tested: the scan uses the old value.
- Reset mid-scan: return to IDLE, clear all outputs, no o_done.
- Outputs hold between scans.

## Timing
- Reset values: o_busy, o_done, o_slot_vld, o_slot_id, o_overflow, o_ovf_cnt all 0.
- i_line high in cycle t → o_busy high in cycles t+1 .. t+N_SPR.
- o_done and updated outputs appear in cycle t+N_SPR+1. o_busy is low in that cycle.
- i_line in cycle t+N_SPR+1 is accepted, giving back-to-back scans.
- Latency N_SPR+1 cycles, which must be less than the blanking width.

## Configuration
- SPRITE_SCHED_OVF_CNT_EN defined:
  - o_ovf_cnt increments by 1, saturating at 255, on each o_done with o_overflow = 1;
  - it clears on i_frame;
  - if i_frame and an increment coincide, the counter becomes 0.
- Undefined: o_ovf_cnt is tied to 0 and no counter register exists.

## Structure
- Package sprite_sched_pkg holds:
  - enum sched_state_t {IDLE, SCAN};
  - struct obj_t {en, y, h};
  - default N_SPR/SLOTS constants.
- Sub-module spr_line_hit: combinational signed range compare (obj_t, L) → hit. It is reused by the collision logic.

## Test plan
- Reset: assert i_rst_n=0 for 2 cycles → all outputs 0 and no o_done.
- Single hit, entry 3 = {en=1, y=100, h=27}:
  - i_line with i_sy=99 → o_done at t+9, o_slot_vld=0001, slot0=3, o_overflow=0;
  - i_sy=126 → o_slot_vld=0000.
- Overflow, entries 0–5 = {1, 0, 50}, i_sy=9 → slots 0,1,2,3, o_slot_vld=1111, o_overflow=1.
  - With the macro: o_ovf_cnt=1, and 0 after i_frame.
- Negative y, entry 0 = {1, -10, 20}:
  - i_sy=-1 → slot0=0, vld=0001;
  - i_sy=9 → vld=0000.
- Busy/reset:
  - i_line at t+3 during a scan → single o_done at t+9;
  - reset at t+4 → no o_done, outputs 0.
- Write race: while idx=2, write entry 2 en=0 (old en=1, hit) → entry 2 still appears in slots. The next scan excludes it.
